// File: rtl/spwm_demod.sv
// spwm_demod: sine-PWM stream demodulator.
// Measures duty/period per frame and recovers amplitude index and sine phase.
module spwm_demod #(
    parameter int TIMEOUT    = 127,
    parameter int MIN_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic       sample_valid,
    output logic [6:0] duty_out,
    output logic [6:0] period_out,
    output logic [4:0] amp_idx,
    output logic [5:0] sel_est,
    output logic       stuck,
    output logic       glitch_err
);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    localparam logic [6:0] TO_LAST = 7'(TIMEOUT - 1);
    localparam logic [6:0] MIN_P   = 7'(MIN_PERIOD);
    localparam logic [6:0] CNT_MAX = 7'd127;

    state_t     state;
    state_t     state_nxt;

    logic       s1;
    logic       s2;
    logic       s3;
    logic       rise;
    logic       timeout_hit;

    logic [6:0] period_cnt;
    logic [6:0] high_cnt;
    logic [6:0] period_nxt;
    logic [6:0] high_nxt;

    logic       pub;
    logic       pub_stuck;
    logic       glitch;

    logic       cap_valid;
    logic       cap_stuck;
    logic [6:0] cap_duty;
    logic [6:0] cap_period;

    logic       dir_rise;
    logic       dir_nxt;
    logic [4:0] last_amp;
    logic [4:0] amp_calc;
    logic [5:0] sel_calc;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise        = s2 & ~s3;
    assign timeout_hit = (period_cnt >= TO_LAST) & ~rise;

    // Next state, counter update and publish/glitch decision
    always_comb begin
        state_nxt  = state;
        pub        = 1'b0;
        pub_stuck  = 1'b0;
        glitch     = 1'b0;
        period_nxt = period_cnt;
        high_nxt   = high_cnt;
        if (period_cnt != CNT_MAX) begin
            period_nxt = period_cnt + 7'd1;
        end
        if (s2 && (high_cnt != CNT_MAX)) begin
            high_nxt = high_cnt + 7'd1;
        end
        if (rise) begin
            period_nxt = 7'd1;
            high_nxt   = 7'd1;
            if (state == IDLE) begin
                state_nxt = ARMED;
            end else if (period_cnt >= MIN_P) begin
                pub = 1'b1;
            end else begin
                glitch     = 1'b1;
                state_nxt  = IDLE;
                period_nxt = 7'd0;
                high_nxt   = 7'd0;
            end
        end else if (timeout_hit) begin
            pub        = 1'b1;
            pub_stuck  = 1'b1;
            state_nxt  = IDLE;
            period_nxt = 7'd0;
            high_nxt   = 7'd0;
        end
    end

    // Measurement state and capture of the raw sample to publish
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            period_cnt <= 7'd0;
            high_cnt   <= 7'd0;
            cap_valid  <= 1'b0;
            cap_stuck  <= 1'b0;
            cap_duty   <= 7'd0;
            cap_period <= 7'd0;
            glitch_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            period_cnt <= period_nxt;
            high_cnt   <= high_nxt;
            cap_valid  <= pub;
            glitch_err <= glitch;
            if (pub) begin
                cap_stuck <= pub_stuck;
                if (pub_stuck) begin
                    cap_duty   <= s2 ? CNT_MAX : 7'd0;
                    cap_period <= 7'd0;
                end else begin
                    cap_duty   <= high_cnt;
                    cap_period <= period_cnt;
                end
            end
        end
    end

    // Nearest amplitude-table index for the captured duty
    always_comb begin
        amp_calc = 5'd18;
        if (cap_duty < 7'd5) begin
            amp_calc = 5'd0;
        end else if (cap_duty < 7'd14) begin
            amp_calc = 5'd1;
        end else if (cap_duty < 7'd22) begin
            amp_calc = 5'd2;
        end else if (cap_duty < 7'd31) begin
            amp_calc = 5'd3;
        end else if (cap_duty < 7'd39) begin
            amp_calc = 5'd4;
        end else if (cap_duty < 7'd47) begin
            amp_calc = 5'd5;
        end else if (cap_duty < 7'd54) begin
            amp_calc = 5'd6;
        end else if (cap_duty < 7'd61) begin
            amp_calc = 5'd7;
        end else if (cap_duty < 7'd68) begin
            amp_calc = 5'd8;
        end else if (cap_duty < 7'd75) begin
            amp_calc = 5'd9;
        end else if (cap_duty < 7'd80) begin
            amp_calc = 5'd10;
        end else if (cap_duty < 7'd85) begin
            amp_calc = 5'd11;
        end else if (cap_duty < 7'd89) begin
            amp_calc = 5'd12;
        end else if (cap_duty < 7'd92) begin
            amp_calc = 5'd13;
        end else if (cap_duty < 7'd95) begin
            amp_calc = 5'd14;
        end else if (cap_duty < 7'd97) begin
            amp_calc = 5'd15;
        end else if (cap_duty < 7'd98) begin
            amp_calc = 5'd16;
        end else if (cap_duty < 7'd99) begin
            amp_calc = 5'd17;
        end
    end

    // Slope direction and phase estimate from amplitude trend
    always_comb begin
        dir_nxt = dir_rise;
        if (amp_calc == 5'd0) begin
            dir_nxt = 1'b1;
        end else if (amp_calc > last_amp) begin
            dir_nxt = 1'b1;
        end else if (amp_calc < last_amp) begin
            dir_nxt = 1'b0;
        end
        if (dir_nxt) begin
            sel_calc = {1'b0, amp_calc};
        end else begin
            sel_calc = 6'd36 - {1'b0, amp_calc};
        end
    end

    // Output register stage; all sample fields change with sample_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            duty_out     <= 7'd0;
            period_out   <= 7'd0;
            amp_idx      <= 5'd0;
            sel_est      <= 6'd0;
            stuck        <= 1'b0;
            dir_rise     <= 1'b1;
            last_amp     <= 5'd0;
        end else begin
            sample_valid <= cap_valid;
            if (cap_valid) begin
                duty_out   <= cap_duty;
                period_out <= cap_period;
                amp_idx    <= amp_calc;
                sel_est    <= sel_calc;
                stuck      <= cap_stuck;
                dir_rise   <= dir_nxt;
                last_amp   <= amp_calc;
            end
        end
    end

endmodule

// File: tb/tb_spwm_demod.sv
// tb_spwm_demod: directed PWM frames for spwm_demod.
// Driver queues expected samples; an independent monitor pops and compares.
module tb_spwm_demod;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm_in;
    logic       sample_valid;
    logic [6:0] duty_out;
    logic [6:0] period_out;
    logic [4:0] amp_idx;
    logic [5:0] sel_est;
    logic       stuck;
    logic       glitch_err;

    spwm_demod #(
        .TIMEOUT   (127),
        .MIN_PERIOD(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .sample_valid(sample_valid),
        .duty_out    (duty_out),
        .period_out  (period_out),
        .amp_idx     (amp_idx),
        .sel_est     (sel_est),
        .stuck       (stuck),
        .glitch_err  (glitch_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit glitch;
        int duty;
        int period;
        int amp;
        int sel;
        bit stk;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // duty per amplitude index, one value inside each threshold band
    int dtab[19] = '{0, 9, 17, 26, 34, 42, 50, 57, 64, 71,
                     77, 82, 87, 90, 93, 96, 97, 98, 100};

    // boundary duties with hand-derived amp/sel
    int bd_d[10] = '{4, 5, 21, 22, 96, 97, 99, 88, 89, 50};
    int bd_a[9]  = '{0, 1, 2, 3, 15, 16, 18, 12, 13};
    int bd_s[9]  = '{0, 1, 2, 3, 15, 16, 18, 24, 13};

    function automatic int ampof(int s);
        return (s <= 18) ? s : 36 - s;
    endfunction

    task automatic push_s(int d, int p, int a, int s, bit st, int at);
        exp_t e;
        e.glitch = 1'b0;
        e.duty   = d;
        e.period = p;
        e.amp    = a;
        e.sel    = s;
        e.stk    = st;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic push_g();
        exp_t e;
        e.glitch = 1'b1;
        e.duty   = 0;
        e.period = 0;
        e.amp    = 0;
        e.sel    = 0;
        e.stk    = 1'b0;
        e.at     = -1;
        sb.push_back(e);
    endtask

    task automatic ticks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(string nm);
        n_cmp++;
        if (sample_valid || glitch_err || stuck || duty_out != 0 ||
            period_out != 0 || amp_idx != 0 || sel_est != 0) begin
            n_bad++;
            $display("FAIL %s: got sv=%0b ge=%0b stuck=%0b duty=%0d per=%0d amp=%0d sel=%0d, required all 0",
                     nm, sample_valid, glitch_err, stuck, duty_out,
                     period_out, amp_idx, sel_est);
        end
    endtask

    task automatic do_reset(string nm);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d outputs still pending, required 0",
                     nm, sb.size());
            sb.delete();
        end
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        ticks(2);
        chk_zero(nm);
        rst_n = 1'b1;
    endtask

    task automatic frame(int d);
        for (int i = 0; i < 101; i++) begin
            pwm_in = (i < d);
            @(negedge clk);
        end
    endtask

    task automatic run_frame(int d, bit pub, int pd, int pa, int ps);
        if (pub) push_s(pd, 101, pa, ps, 1'b0, cyc + 4);
        frame(d);
    endtask

    // Monitor: every sample_valid/glitch_err pulse consumes one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_valid || glitch_err) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra: got sv=%0b ge=%0b duty=%0d at cyc=%0d, required no output",
                             sample_valid, glitch_err, duty_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.glitch) begin
                        if (!glitch_err || sample_valid) begin
                            n_bad++;
                            $display("FAIL glitch: got sv=%0b ge=%0b, required sv=0 ge=1",
                                     sample_valid, glitch_err);
                        end
                    end else if (!sample_valid || glitch_err ||
                                 duty_out != e.duty || period_out != e.period ||
                                 amp_idx != e.amp || sel_est != e.sel ||
                                 stuck != e.stk || (e.at >= 0 && cyc != e.at)) begin
                        n_bad++;
                        $display("FAIL sample: got sv=%0b ge=%0b duty=%0d per=%0d amp=%0d sel=%0d stuck=%0b cyc=%0d, required duty=%0d per=%0d amp=%0d sel=%0d stuck=%0b cyc=%0d",
                                 sample_valid, glitch_err, duty_out, period_out,
                                 amp_idx, sel_est, stuck, cyc, e.duty, e.period,
                                 e.amp, e.sel, e.stk, e.at);
                    end
                end
            end
        end
    end

    // Watchdog against a stalled run
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2000000, required finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int r;
        int c;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        @(negedge clk);

        // stuck low from reset, then stuck high
        do_reset("reset_a");
        r = cyc;
        push_s(0, 0, 0, 0, 1'b1, r + 128);
        push_s(0, 0, 0, 0, 1'b1, r + 255);
        ticks(300);
        c = cyc;
        pwm_in = 1'b1;
        push_s(127, 0, 18, 18, 1'b1, c + 130);
        push_s(127, 0, 18, 18, 1'b1, c + 257);
        ticks(300);

        // steady D=50 with a short-period glitch
        do_reset("reset_b");
        run_frame(50, 1'b0, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_frame(50, 1'b1, 50, 6, 6);
        push_s(50, 101, 6, 6, 1'b0, cyc + 4);
        push_g();
        for (int i = 0; i < 101; i++) begin
            pwm_in = (i < 3) || (i >= 5 && i < 50);
            @(negedge clk);
        end
        run_frame(50, 1'b0, 0, 0, 0);
        run_frame(50, 1'b1, 50, 6, 6);
        run_frame(50, 1'b1, 50, 6, 6);

        // D=77 stream with reset in the low part of a frame
        do_reset("reset_c");
        run_frame(77, 1'b0, 0, 0, 0);
        run_frame(77, 1'b1, 77, 10, 10);
        run_frame(77, 1'b1, 77, 10, 10);
        push_s(77, 101, 10, 10, 1'b0, cyc + 4);
        for (int i = 0; i < 101; i++) begin
            if (i == 85) rst_n = 1'b0;
            if (i == 87) begin
                chk_zero("midframe_reset");
                rst_n = 1'b1;
            end
            pwm_in = (i < 77);
            @(negedge clk);
        end
        run_frame(77, 1'b0, 0, 0, 0);
        run_frame(77, 1'b1, 77, 10, 10);
        run_frame(77, 1'b1, 77, 10, 10);

        // full sine sweep after a stuck-low start
        do_reset("reset_d");
        r = cyc;
        push_s(0, 0, 0, 0, 1'b1, r + 128);
        ticks(130);
        c = 0;
        for (int s = 0; s <= 36; s++) begin
            if (s == 35) c = cyc;
            if (s >= 2 && s <= 35) begin
                push_s(dtab[ampof(s - 1)], 101, ampof(s - 1), s - 1,
                       1'b0, cyc + 4);
            end
            if (s == 36) push_s(0, 0, 0, 0, 1'b1, c + 130);
            frame(dtab[ampof(s)]);
        end

        // amplitude threshold boundaries and direction changes
        do_reset("reset_e");
        for (int k = 0; k < 10; k++) begin
            if (k == 0) run_frame(bd_d[k], 1'b0, 0, 0, 0);
            else run_frame(bd_d[k], 1'b1, bd_d[k - 1], bd_a[k - 1], bd_s[k - 1]);
        end

        do_reset("reset_end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
